// File: rtl/bmp_stream_reader.sv
// bmp_stream_reader: parses a BMP byte stream (54-byte header + 24-bit pixel rows),
// validates the header, and emits one R/G/B pixel per handshake with padding stripped.
module bmp_stream_reader #(
  parameter int unsigned MAX_WIDTH      = 1024,
  parameter int unsigned MAX_HEIGHT     = 1024,
  parameter int unsigned BMP_HEADER_NUM = 54
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic        hdr_error
);

  localparam int unsigned HCNT_W = $clog2(BMP_HEADER_NUM);
  localparam int unsigned DIM_W  = 16;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_PIXELS,
    ST_PAD,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_started;
  logic [HCNT_W-1:0] r_hcnt;
  logic [15:0]       r_magic;
  logic [15:0]       r_bpp;
  logic [31:0]       r_offset;
  logic [31:0]       r_hdr_w;
  logic [31:0]       r_hdr_h;
  logic [31:0]       r_comp;
  logic [1:0]        r_phase;
  logic [1:0]        r_pad;
  logic [7:0]        r_b_hold;
  logic [7:0]        r_g_hold;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [7:0]        r_red;
  logic [7:0]        r_grn;
  logic [7:0]        r_blu;
  logic              r_pix_valid;
  logic              r_sof;
  logic              r_eol;
  logic              r_eof;
  logic              r_hdr_error;

  logic        w_in_ready;
  logic        w_acc;
  logic        w_hdr_last;
  logic        w_hdr_ok;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_has_pad;
  logic        w_pad_last;
  int unsigned w_hidx;

  assign w_hidx     = 32'(r_hcnt);
  assign w_hdr_last = (r_hcnt == HCNT_W'(BMP_HEADER_NUM - 1));
  assign w_hdr_ok   = (r_magic == 16'h4D42) &&
                      (r_offset == 32'(BMP_HEADER_NUM)) &&
                      !r_hdr_w[31] && (r_hdr_w != 32'd0) && (r_hdr_w <= 32'(MAX_WIDTH)) &&
                      !r_hdr_h[31] && (r_hdr_h != 32'd0) && (r_hdr_h <= 32'(MAX_HEIGHT)) &&
                      (r_bpp == 16'd24) && (r_comp == 32'd0);
  assign w_last_col = (r_col == r_width - DIM_W'(1));
  assign w_last_row = (r_row == r_height - DIM_W'(1));
  assign w_has_pad  = (r_width[1:0] != 2'd0);
  assign w_pad_last = (r_pad == r_width[1:0] - 2'd1);

  // Input handshake: pixel bytes need room in the single-entry output register
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_HEADER, ST_PAD, ST_ERROR: w_in_ready = 1'b1;
      ST_PIXELS:                   w_in_ready = !r_pix_valid || pix_ready;
      default:                     w_in_ready = 1'b0;
    endcase
    if (!r_started || clear) w_in_ready = 1'b0;
  end

  assign w_acc = in_valid && w_in_ready;

  // State register plus a flag that holds in_ready low until the first cycle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HEADER;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HEADER: begin
        if (w_acc && w_hdr_last) w_state_nxt = w_hdr_ok ? ST_PIXELS : ST_ERROR;
      end
      ST_PIXELS: begin
        if (w_acc && (r_phase == 2'd2) && w_last_col) begin
          if (w_has_pad)       w_state_nxt = ST_PAD;
          else if (w_last_row) w_state_nxt = ST_DONE;
        end
      end
      ST_PAD: begin
        if (w_acc && w_pad_last) w_state_nxt = w_last_row ? ST_DONE : ST_PIXELS;
      end
      ST_DONE: begin
        if (!r_pix_valid || pix_ready) w_state_nxt = ST_HEADER;
      end
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_HEADER;
    endcase
    if (clear) w_state_nxt = ST_HEADER;
  end

  // Header capture, pixel assembly, output register and frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt      <= '0;
      r_magic     <= '0;
      r_bpp       <= '0;
      r_offset    <= '0;
      r_hdr_w     <= '0;
      r_hdr_h     <= '0;
      r_comp      <= '0;
      r_phase     <= '0;
      r_pad       <= '0;
      r_b_hold    <= '0;
      r_g_hold    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_red       <= '0;
      r_grn       <= '0;
      r_blu       <= '0;
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_hdr_error <= 1'b0;
    end else if (clear) begin
      r_hcnt      <= '0;
      r_phase     <= '0;
      r_pad       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pix_valid <= 1'b0;
      r_hdr_error <= 1'b0;
    end else begin
      if (r_pix_valid && pix_ready) r_pix_valid <= 1'b0;
      if (w_acc) begin
        case (r_state)
          ST_HEADER: begin
            case (w_hidx)
              0:  r_magic[7:0]    <= in_data;
              1:  r_magic[15:8]   <= in_data;
              10: r_offset[7:0]   <= in_data;
              11: r_offset[15:8]  <= in_data;
              12: r_offset[23:16] <= in_data;
              13: r_offset[31:24] <= in_data;
              18: r_hdr_w[7:0]    <= in_data;
              19: r_hdr_w[15:8]   <= in_data;
              20: r_hdr_w[23:16]  <= in_data;
              21: r_hdr_w[31:24]  <= in_data;
              22: r_hdr_h[7:0]    <= in_data;
              23: r_hdr_h[15:8]   <= in_data;
              24: r_hdr_h[23:16]  <= in_data;
              25: r_hdr_h[31:24]  <= in_data;
              28: r_bpp[7:0]      <= in_data;
              29: r_bpp[15:8]     <= in_data;
              30: r_comp[7:0]     <= in_data;
              31: r_comp[15:8]    <= in_data;
              32: r_comp[23:16]   <= in_data;
              33: r_comp[31:24]   <= in_data;
              default: ;
            endcase
            if (w_hdr_last) begin
              r_hcnt <= '0;
              if (w_hdr_ok) begin
                r_width  <= r_hdr_w[DIM_W-1:0];
                r_height <= r_hdr_h[DIM_W-1:0];
                r_col    <= '0;
                r_row    <= '0;
                r_phase  <= '0;
                r_pad    <= '0;
              end else begin
                r_hdr_error <= 1'b1;
              end
            end else begin
              r_hcnt <= r_hcnt + HCNT_W'(1);
            end
          end
          ST_PIXELS: begin
            case (r_phase)
              2'd0: begin
                r_b_hold <= in_data;
                r_phase  <= 2'd1;
              end
              2'd1: begin
                r_g_hold <= in_data;
                r_phase  <= 2'd2;
              end
              default: begin
                r_red       <= in_data;
                r_grn       <= r_g_hold;
                r_blu       <= r_b_hold;
                r_pix_valid <= 1'b1;
                r_sof       <= (r_col == '0) && (r_row == '0);
                r_eol       <= w_last_col;
                r_eof       <= w_last_col && w_last_row;
                r_phase     <= 2'd0;
                if (w_last_col) begin
                  r_col <= '0;
                  if (!w_has_pad && !w_last_row) r_row <= r_row + DIM_W'(1);
                end else begin
                  r_col <= r_col + DIM_W'(1);
                end
              end
            endcase
          end
          ST_PAD: begin
            if (w_pad_last) begin
              r_pad <= '0;
              if (!w_last_row) r_row <= r_row + DIM_W'(1);
            end else begin
              r_pad <= r_pad + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign R         = r_red;
  assign G         = r_grn;
  assign B         = r_blu;
  assign pix_valid = r_pix_valid;
  assign sof       = r_sof;
  assign eol       = r_eol;
  assign eof       = r_eof;
  assign width     = r_width;
  assign height    = r_height;
  assign hdr_error = r_hdr_error;

endmodule

// File: tb/tb_bmp_stream_reader.sv
// Bench for bmp_stream_reader: builds BMP files as byte queues, predicts the pixel
// stream from the file format, and checks every accepted pixel plus header outcomes.
module tb_bmp_stream_reader;

  localparam int MAX_W = 1024;
  localparam int MAX_H = 1024;
  localparam int HDR_N = 54;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  R, G, B;
  logic        pix_valid;
  logic        pix_ready;
  logic        sof, eol, eof;
  logic [15:0] width, height;
  logic        hdr_error;

  bmp_stream_reader #(
    .MAX_WIDTH(MAX_W),
    .MAX_HEIGHT(MAX_H),
    .BMP_HEADER_NUM(HDR_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .R(R), .G(G), .B(B), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof(sof), .eol(eol), .eof(eof),
    .width(width), .height(height), .hdr_error(hdr_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] bq[$];
  pix_t       exp_q[$];
  logic [7:0] seen_r[$];
  int         pix_seen, sof_cnt, eol_cnt, eof_cnt;
  logic [2:0] last_flags;
  logic [15:0] exp_w, exp_h;
  logic       exp_err;
  bit         mon_en, no_pix, prev_stall;
  pix_t       prev_pix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Builds one BMP file into the byte queue and predicts its effect on the outputs
  task automatic add_frame(input int w, input int h, input logic [15:0] magic,
                           input logic [15:0] bpp, input logic [31:0] offs,
                           input logic [31:0] comp, input bit pattern);
    logic [7:0]  hdr [HDR_N];
    logic [31:0] wv, hv;
    bit          good;
    int          pad, k;
    pix_t        p;
    wv = w;
    hv = h;
    for (int i = 0; i < HDR_N; i++) hdr[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      hdr[i]      = magic[8*i +: 8];
      hdr[28 + i] = bpp[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      hdr[10 + i] = offs[8*i +: 8];
      hdr[18 + i] = wv[8*i +: 8];
      hdr[22 + i] = hv[8*i +: 8];
      hdr[30 + i] = comp[8*i +: 8];
    end
    for (int i = 0; i < HDR_N; i++) bq.push_back(hdr[i]);
    good = (magic == 16'h4D42) && (offs == 32'(HDR_N)) && (w >= 1) && (w <= MAX_W) &&
           (h >= 1) && (h <= MAX_H) && (bpp == 16'd24) && (comp == 32'd0);
    if (!good) begin
      exp_err = 1'b1;
      return;
    end
    if (!exp_err) begin
      exp_w = 16'(w);
      exp_h = 16'(h);
    end
    pad = (4 - (3 * w) % 4) % 4;
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (pattern) begin
          p.b = 8'(3 * k + 1);
          p.g = 8'(3 * k + 2);
          p.r = 8'(3 * k + 3);
        end else begin
          {p.r, p.g, p.b} = 24'($urandom);
        end
        p.sof = (r == 0) && (c == 0);
        p.eol = (c == w - 1);
        p.eof = (c == w - 1) && (r == h - 1);
        bq.push_back(p.b);
        bq.push_back(p.g);
        bq.push_back(p.r);
        if (!exp_err) exp_q.push_back(p);
        k++;
      end
      for (int i = 0; i < pad; i++) bq.push_back(8'hEE);
    end
  endtask

  // Feeds the byte queue with random gaps and random downstream back-pressure
  task automatic run_stream(input int vpct, input int rpct, input int stop_pix);
    int cyc;
    cyc = 0;
    while ((bq.size() > 0 || exp_q.size() > 0) && !(stop_pix >= 0 && pix_seen >= stop_pix)
           && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = (bq.size() > 0) && ($urandom_range(99) < vpct);
      in_data   = in_valid ? bq[0] : 8'($urandom);
      pix_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) void'(bq.pop_front());
      cyc++;
    end
    chk("stream_within_budget", 32'(cyc < 20000), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic frame_checks(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hdr_error"}, 32'(hdr_error), 32'(exp_err));
    chk({tag, "_width"}, 32'(width), 32'(exp_w));
    chk({tag, "_height"}, 32'(height), 32'(exp_h));
    chk({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h42;
    clear    = 1'b1;
    @(negedge clk);
    chk("clear_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_err  = 1'b0;
    exp_q.delete();
    chk("clear_hdr_error", 32'(hdr_error), 32'd0);
  endtask

  task automatic reset_counts();
    pix_seen = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
    seen_r.delete();
  endtask

  task automatic bad_case(input string tag, input int w, input int h, input logic [15:0] magic,
                          input logic [15:0] bpp, input logic [31:0] offs, input logic [31:0] comp);
    add_frame(w, h, magic, bpp, offs, comp, 1'b0);
    run_stream(100, 100, -1);
    frame_checks(tag);
    chk({tag, "_err_set"}, 32'(hdr_error), 32'd1);
    do_clear();
  endtask

  // Pixel monitor: every accepted pixel against the prediction, plus stall stability
  always @(negedge clk) begin
    pix_t cur;
    cur = {R, G, B, sof, eol, eof};
    if (mon_en && rst_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", 32'(pix_valid), 32'd1);
        chk("stall_pixel_held", 32'(cur), 32'(prev_pix));
      end
      if (no_pix) chk("error_no_pixel", 32'(pix_valid), 32'd0);
      if (pix_valid && pix_ready) begin
        pix_seen++;
        seen_r.push_back(R);
        if (sof) sof_cnt++;
        if (eol) eol_cnt++;
        if (eof) eof_cnt++;
        last_flags = {sof, eol, eof};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel actual=0x%0h required=none", cur);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("pixel", 32'(cur), 32'(e));
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; pix_ready = 1'b1;
    mon_en = 1'b0; no_pix = 1'b0; prev_stall = 1'b0;
    exp_w = '0; exp_h = '0; exp_err = 1'b0;
    reset_counts();

    // Reset values and in_ready rising one cycle after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, pix_valid, R, G, B, sof, eol, eof, hdr_error}, 32'd0);
    chk("reset_dims", {width, height}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_low_at_release", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_high_after_release", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // 2x2 with known pixels and 2 pad bytes per row
    add_frame(2, 2, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b1);
    chk("tc1_byte_count", 32'(bq.size()), 32'd70);
    reset_counts();
    run_stream(100, 100, -1);
    frame_checks("tc1");
    chk("tc1_npix", 32'(seen_r.size()), 32'd4);
    if (seen_r.size() == 4) begin
      chk("tc1_r0", 32'(seen_r[0]), 32'd3);
      chk("tc1_r1", 32'(seen_r[1]), 32'd6);
      chk("tc1_r2", 32'(seen_r[2]), 32'd9);
      chk("tc1_r3", 32'(seen_r[3]), 32'd12);
    end
    chk("tc1_flag_counts", {8'(sof_cnt), 8'(eol_cnt), 8'(eof_cnt)}, 32'h010201);
    chk("tc1_width", 32'(width), 32'd2);

    // 3x1 then 4x1 back-to-back
    add_frame(3, 1, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b0);
    add_frame(4, 1, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b0);
    reset_counts();
    run_stream(100, 100, -1);
    frame_checks("tc2");
    chk("tc2_npix", 32'(pix_seen), 32'd7);
    chk("tc2_sof_count", 32'(sof_cnt), 32'd2);

    // bpp=32 rejected; error state drops everything
    bad_case_free: begin
      add_frame(4, 3, 16'h4D42, 16'd32, 32'd54, 32'd0, 1'b0);
      run_stream(100, 100, -1);
      frame_checks("tc3");
      chk("tc3_err", 32'(hdr_error), 32'd1);
      no_pix = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        chk("tc3_error_ready", 32'(in_ready), 32'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      no_pix = 1'b0;
      do_clear();
      add_frame(1, 1, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b0);
      reset_counts();
      run_stream(100, 100, -1);
      frame_checks("tc3b");
      chk("tc3b_npix", 32'(pix_seen), 32'd1);
      chk("tc3b_flags", 32'(last_flags), 32'd7);
    end

    // Other rejected headers keep the previous dimensions
    bad_case("bad_magic", 2, 2, 16'h4E42, 16'd24, 32'd54, 32'd0);
    chk("bad_magic_width_kept", 32'(width), 32'd1);
    bad_case("bad_width", MAX_W + 1, 1, 16'h4D42, 16'd24, 32'd54, 32'd0);
    bad_case("bad_height_neg", 2, -2, 16'h4D42, 16'd24, 32'd54, 32'd0);
    bad_case("bad_offset", 2, 2, 16'h4D42, 16'd24, 32'd55, 32'd0);
    bad_case("bad_comp", 2, 2, 16'h4D42, 16'd24, 32'd54, 32'd1);
    chk("bad_height_kept", 32'(height), 32'd1);

    // 2x2 under back-pressure and input gaps
    add_frame(2, 2, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b1);
    reset_counts();
    run_stream(60, 50, -1);
    frame_checks("tc5");
    chk("tc5_npix", 32'(seen_r.size()), 32'd4);
    if (seen_r.size() == 4) chk("tc5_last_r", 32'(seen_r[3]), 32'd12);

    // Random frames back-to-back
    for (int f = 0; f < 5; f++)
      add_frame($urandom_range(7, 1), $urandom_range(4, 1), 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b0);
    reset_counts();
    run_stream(70, 60, -1);
    frame_checks("rand");

    // Reset after the first pixel of a frame, then a full frame
    add_frame(2, 2, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b1);
    reset_counts();
    run_stream(100, 100, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_outputs", {in_ready, pix_valid, R, G, B, sof, eol, eof, hdr_error}, 32'd0);
    chk("midrst_dims", {width, height}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bq.delete();
    exp_q.delete();
    exp_w = '0; exp_h = '0; exp_err = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    add_frame(3, 2, 16'h4D42, 16'd24, 32'd54, 32'd0, 1'b0);
    reset_counts();
    run_stream(80, 70, -1);
    frame_checks("postrst");
    chk("postrst_npix", 32'(pix_seen), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
